// File: rtl/spi_apb_master.sv
// -----------------------------------------------------------------------------
// spi_apb_master
//   APB3 initiator. It turns single-beat host requests into APB transfers, with
//   one transfer outstanding at a time. Each transfer runs SETUP then ACCESS,
//   honours PREADY wait states and captures PSLVERR. An optional timeout aborts
//   a transfer that waits in ACCESS for too long.
//
// Ports
//   HCLK, HRESETn           clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake; req_ready = (state == IDLE)
//   req_addr/write/wdata    request payload (byte address, direction, data)
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata               read data (0 for writes and for aborted transfers)
//   rsp_err                 PSLVERR seen, or the transfer timed out
//   rsp_timeout             transfer aborted by the wait-state timeout
//   busy                    state != IDLE
//   PADDR..PENABLE          APB request outputs, all registered
//   PRDATA/PREADY/PSLVERR   APB completer inputs, sampled only in ACCESS
// -----------------------------------------------------------------------------
module spi_apb_master #(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [APB_ADDR_WIDTH-1:0] req_addr,
   input  logic                      req_write,
   input  logic [31:0]               req_wdata,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [31:0]               rsp_rdata,
   output logic                      rsp_err,
   output logic                      rsp_timeout,
   output logic                      busy,
   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic [31:0]               PWDATA,
   output logic                      PWRITE,
   output logic                      PSEL,
   output logic                      PENABLE,
   input  logic [31:0]               PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   // A zero TIMEOUT_CYCLES disables the abort. TMO_LAST is then unused.
   localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [15:0] tmo_cnt;
   logic        tmo_hit;
   logic        addr_lsb_unused;

   // APB addresses are word aligned, so the byte-lane bits are dropped.
   assign addr_lsb_unused = ^req_addr[1:0];

   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);

   // The abort fires in the ACCESS cycle where the counter already holds
   // TIMEOUT_CYCLES-1. That gives exactly TIMEOUT_CYCLES ACCESS cycles. If
   // PREADY is high in that same cycle, the transfer completes normally.
   assign tmo_hit = TMO_EN && !PREADY && (tmo_cnt == TMO_LAST);

   // NOTE: state registers use non-blocking assignments, so every flop
   // samples pre-edge values and the result does not depend on process order.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // NOTE: state_d gets its default before the case. Without it, any path
   // that leaves state_d unassigned would infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (req_valid)          state_d = SETUP;
         SETUP:                           state_d = ACCESS;
         ACCESS:  if (PREADY || tmo_hit)  state_d = RESP;
         RESP:    if (rsp_ready)          state_d = IDLE;
         default:                         state_d = IDLE;
      endcase
   end

   // NOTE: the reset is asynchronous. If HRESETn falls mid-transfer, PSEL and
   // PENABLE drop at once without waiting for a clock edge, and the transfer
   // is abandoned with no response.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         PADDR       <= '0;
         PWDATA      <= '0;
         PWRITE      <= 1'b0;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         tmo_cnt     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  PADDR   <= {req_addr[APB_ADDR_WIDTH-1:2], 2'b00};
                  PWRITE  <= req_write;
                  // Reads leave PWDATA at its previous value.
                  if (req_write) PWDATA <= req_wdata;
                  PSEL    <= 1'b1;
                  PENABLE <= 1'b0;
               end
            end
            SETUP: begin
               PENABLE <= 1'b1;
               tmo_cnt <= '0;
            end
            ACCESS: begin
               if (PREADY) begin
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
                  rsp_rdata   <= PWRITE ? 32'h0 : PRDATA;
                  rsp_err     <= PSLVERR;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= 1'b1;
               end else begin
                  // The counter saturates and never wraps.
                  if (tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
                  if (tmo_hit) begin
                     PSEL        <= 1'b0;
                     PENABLE     <= 1'b0;
                     rsp_rdata   <= 32'h0;
                     rsp_err     <= 1'b1;
                     rsp_timeout <= 1'b1;
                     rsp_valid   <= 1'b1;
                  end
               end
            end
            RESP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/spi_apb_master.md
Name: spi_apb_master

Overview:
- APB3 initiator that turns single-beat host requests into APB transfers. It drives the APB completer side of the SPI controller's register file and any other APB completer.
- Sits between a simple command source (boot sequencer, debug bridge or test driver) and the APB bus.
- Runs one outstanding transfer at a time, with full SETUP/ACCESS sequencing, PREADY wait states, PSLVERR capture and an optional wait-state timeout.

Parameters:
- APB_ADDR_WIDTH, 12, width of PADDR and req_addr. 4 KB completer window.
- TIMEOUT_CYCLES, 256, number of consecutive ACCESS cycles with PREADY low before the transfer is aborted. 0 disables the timeout. Legal range 0..65535.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on a cycle where req_valid && req_ready.
- req_addr  in  APB_ADDR_WIDTH  byte address.
- req_write  in  1  1 = write, 0 = read.
- req_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed on a cycle where rsp_valid && rsp_ready.
- rsp_rdata  out  32  read data. 0 for writes and for aborted transfers.
- rsp_err  out  1  PSLVERR was seen, or the transfer timed out.
- rsp_timeout  out  1  transfer aborted by the timeout.
- busy  out  1  state != IDLE.
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Clock and reset: single clock HCLK. HRESETn is asynchronous and active-low. All outputs are driven from registers, except req_ready (= state==IDLE) and busy (= state!=IDLE).
- Reset values: state IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0; rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0; timeout counter 0.
- Reset asserted mid-transfer: PSEL and PENABLE drop immediately (asynchronously). The transfer is lost and no response is produced.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture into PADDR/PWRITE/PWDATA: PADDR = {req_addr[APB_ADDR_WIDTH-1:2], 2'b00}; PWDATA = req_wdata if write, else keep the previous value.
  - Set PSEL=1, PENABLE=0. Go to SETUP.
- SETUP: exactly one cycle. Set PENABLE=1, clear the timeout counter, go to ACCESS.
- ACCESS, with PREADY=1:
  - Clear PSEL and PENABLE.
  - rsp_rdata = PWRITE ? 0 : PRDATA; rsp_err = PSLVERR; rsp_timeout = 0; rsp_valid = 1.
  - Go to RESP.
- ACCESS, with PREADY=0:
  - Counter increments.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 in a cycle where PREADY is still 0: clear PSEL/PENABLE; rsp_rdata=0, rsp_err=1, rsp_timeout=1, rsp_valid=1; go to RESP.
  - PREADY=1 in that same cycle wins: normal completion.
- RESP: rsp_valid held high, with rsp_* stable, until rsp_ready. On the handshake, clear rsp_valid and go to IDLE.
- Request handling during a transfer: req_ready stays 0 outside IDLE. req_* changes while not in IDLE are ignored.
- Bus signal stability: PADDR, PWRITE and PWDATA are stable from SETUP through the completing ACCESS cycle. They hold their last values after completion.
- Latency, zero-wait completer: request accepted at edge N; PSEL=1 after N; PENABLE=1 after N+1; rsp_valid=1 after N+2. Minimum request-to-request spacing is 4 cycles when rsp_ready is tied high.
- PREADY/PSLVERR/PRDATA are sampled only in ACCESS. PREADY outside ACCESS is ignored.
- The counter saturates and never wraps. Width is 16 bits.

Test Plan:
- Write CLKDIV: req addr=0x004, write=1, wdata=0x15, zero-wait completer. Expect:
  - PSEL high 2 cycles, PENABLE high 1 cycle, PADDR=0x004, PWDATA=0x15.
  - rsp_valid 3 cycles after acceptance, with rsp_err=0 and rsp_rdata=0.
  - Completer spi_clk_div=0x15.
- Read RXFIFO: req addr=0x020, write=0, completer PRDATA=0xA5A5_1234 with PREADY low for 3 ACCESS cycles. Expect:
  - PENABLE high 4 cycles.
  - rsp_rdata=0xA5A5_1234, rsp_err=0.
  - Completer spi_data_rx_ready pulses once.
- Error completion: PSLVERR=1 together with PREADY=1 on a read of addr 0x028. Expect rsp_err=1, rsp_timeout=0, rsp_rdata=PRDATA.
- Timeout: TIMEOUT_CYCLES=8, PREADY stuck at 0. Expect:
  - PSEL drops after 8 ACCESS cycles.
  - rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - The next request proceeds normally.
- Backpressure: rsp_ready held 0 for 5 cycles, with req_valid held high carrying a second request. Expect:
  - rsp_* stable and req_ready=0 throughout.
  - Second request accepted the cycle after the response handshake.
- Reset mid-ACCESS: assert HRESETn=0 while PENABLE=1. Expect:
  - PSEL/PENABLE=0 without waiting for a clock edge.
  - rsp_valid=0, state IDLE.
  - After reset release, a write to 0x008 with 0x9F completes normally.
